ahb_lite_sram_slave: RTL and testbench
======================================

AHB_LITE_SRAM_SLAVE -- requirements
Module: ahb_lite_sram_slave

Interface
REQ-001 SHALL have parameter MEM_AW, default 12, word-address width (memory = 4*2^MEM_AW bytes).
REQ-002 SHALL have parameter WAIT_STATES, default 0, extra data-phase cycles per OKAY transfer (legal 0..7).
REQ-003 SHALL have port HCLK input 1: the only clock; one clock; all logic on rising edge.
REQ-004 SHALL have port HRESET input 1: reset, synchronous, active-high.
REQ-005 SHALL have port HSEL input 1: slave select.
REQ-006 SHALL have port HADDR input 32: transfer address.
REQ-007 SHALL have port HTRANS input 2: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-008 SHALL have port HSIZE input 3: 0 byte, 1 halfword, 2 word.
REQ-009 SHALL have port HWRITE input 1: 1 write, 0 read.
REQ-010 SHALL have port HWDATA input 32: write data, valid in data phase.
REQ-011 SHALL have port HREADY input 1: bus-level ready, qualifies address phase.
REQ-012 SHALL have ports HBURST input 3, HPROT input 4, HMASTLOCK input 1: accepted, ignored.
REQ-013 SHALL have port HRDATA output 32: read data.
REQ-014 SHALL have port HREADYOUT output 1: slave ready.
REQ-015 SHALL have port HRESP output 1: 0 OKAY, 1 ERROR.

Function
REQ-016 SHALL accept a transfer when HSEL & HREADY & HTRANS[1] at a rising edge; else the next data phase is zero-wait OKAY.
REQ-017 SHALL flag a transfer as error when HSIZE>2, or HADDR not aligned to HSIZE, or HADDR >= 4*2^MEM_AW.
REQ-018 SHALL respond to an error transfer with two cycles: ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1); no memory write.
REQ-019 SHALL insert exactly WAIT_STATES cycles of HREADYOUT=0, HRESP=0 before the final HREADYOUT=1 cycle of an OKAY transfer.
REQ-020 SHALL implement states IDLE, WAIT, ERR1, ERR2: IDLE->WAIT (OKAY, WAIT_STATES>0), IDLE->ERR1 (error), WAIT->IDLE when wait count reaches WAIT_STATES, ERR1->ERR2, ERR2->IDLE; a new accepted transfer in the final ready cycle SHALL be decoded immediately.
REQ-021 SHALL derive byte strobes from HSIZE and HADDR[1:0] (byte: 1 lane; half: lanes {1:0} or {3:2}; word: all four), little-endian.
REQ-022 SHALL commit write bytes into the array on the edge ending the write data phase (HREADYOUT=1).
REQ-023 SHALL issue array read in the address phase; HRDATA SHALL be valid and stable in the final data-phase cycle, full 32-bit word regardless of HSIZE.
REQ-024 SHALL forward: if a read address phase coincides with the completing data phase of a write to the same word, HRDATA SHALL show the written bytes merged over old array data.
REQ-025 SHALL drive HRDATA=0 during write, error, and idle data phases.
REQ-026 SHALL treat back-to-back pipelined transfers (address N+1 during data N) with zero bubbles when WAIT_STATES=0.

Reset
REQ-027 SHALL, while HRESET=1 at an edge, set state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, wait counter 0, pending data-phase and forwarding flags cleared.
REQ-028 SHALL discard an in-flight write when reset arrives mid data phase; array contents SHALL not be reset.

Structure
REQ-029 SHALL place HTRANS/HSIZE/HRESP encodings and the state enumeration in shared package ahb_lite_pkg.
REQ-030 SHALL instantiate one sub-module ahb_lite_sram_array: single-port synchronous RAM, 2^MEM_AW x 32, 4 byte enables, one-cycle read, read-during-write returns old data.

Verification
REQ-031 SHALL cover: WAIT_STATES=0, word write 0xDEADBEEF @0x10 then read @0x10 -> HRDATA=0xDEADBEEF, HREADYOUT never low.
REQ-032 SHALL cover: byte write 0xAA @0x13 over word 0x11223344, back-to-back read @0x10 -> forwarded HRDATA=0xAA223344.
REQ-033 SHALL cover: halfword read @0x01 -> ERR1 (HREADYOUT=0,HRESP=1), ERR2 (HREADYOUT=1,HRESP=1), memory unchanged.
REQ-034 SHALL cover: WAIT_STATES=3, read @0x20 -> exactly 3 cycles HREADYOUT=0 then data with HRESP=0.
REQ-035 SHALL cover: address 0x4000 with MEM_AW=12 -> two-cycle ERROR; following IDLE -> zero-wait OKAY.
REQ-036 SHALL cover: HRESET asserted during write data phase with WAIT_STATES=2 -> next cycle HREADYOUT=1, HRESP=0, target word unchanged.

Source files
------------

// File: rtl/ahb_lite_pkg.sv
// ahb_lite_pkg: AHB-Lite encodings, slave FSM states and transfer decode helpers
package ahb_lite_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;
  localparam logic [2:0] HSIZE_BYTE    = 3'd0;
  localparam logic [2:0] HSIZE_HALF    = 3'd1;
  localparam logic [2:0] HSIZE_WORD    = 3'd2;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;
  function automatic logic [3:0] byte_strobes(input logic [2:0] size, input logic [1:0] lsb);
    return size == HSIZE_BYTE ? 4'b0001 << lsb :
           size == HSIZE_HALF ? (lsb[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction
  function automatic logic size_err(input logic [2:0] size, input logic [1:0] lsb);
    return size > HSIZE_WORD || (size == HSIZE_HALF && lsb[0]) || (size == HSIZE_WORD && lsb != 2'b00);
  endfunction
endpackage

// File: rtl/ahb_lite_sram_array.sv
// ahb_lite_sram_array: byte-enabled 32-bit word RAM, registered read returning old data on collision
module ahb_lite_sram_array #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);
  logic [31:0] mem [2**AW];
  // byte-lane writes and one-cycle read; nonblocking update makes a same-edge read see old contents
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we && be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/ahb_lite_sram_slave.sv
// ahb_lite_sram_slave: AHB-Lite SRAM slave with configurable wait states, error response and write-to-read forwarding
module ahb_lite_sram_slave
  import ahb_lite_pkg::*;
#(
  parameter int MEM_AW      = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic        HMASTLOCK,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);
  state_t state, state_n;
  logic [2:0] cnt, cnt_n;
  logic acc, err, ok, commit, dp_valid, dp_write, rd_phase, fwd;
  logic [3:0] be, dp_be, fwd_be;
  logic [MEM_AW-1:0] word, dp_word;
  logic [31:0] rdata, fwd_data;
  logic unused;
  assign unused = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};
  assign acc = HSEL & HREADY & HTRANS[1];
  assign err = size_err(HSIZE, HADDR[1:0]) | (|HADDR[31:MEM_AW+2]);
  assign ok = acc & ~err;
  assign be = byte_strobes(HSIZE, HADDR[1:0]);
  assign word = HADDR[MEM_AW+1:2];
  assign HREADYOUT = state == ST_IDLE || state == ST_ERR2;
  assign HRESP = (state == ST_ERR1 || state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
  assign commit = dp_valid & dp_write & HREADYOUT & ~HRESET;
  for (genvar i = 0; i < 4; i++)
    assign HRDATA[8*i +: 8] = !rd_phase ? 8'h00 : (fwd && fwd_be[i]) ? fwd_data[8*i +: 8] : rdata[8*i +: 8];
  ahb_lite_sram_array #(.AW(MEM_AW)) u_array (
    .clk(HCLK),
    .we(commit),
    .be(dp_be),
    .waddr(dp_word),
    .wdata(HWDATA),
    .re(ok & ~HWRITE),
    .raddr(word),
    .rdata(rdata)
  );
  // next state: a transfer accepted in any ready cycle is decoded straight away
  always_comb begin
    state_n = state;
    case (state)
      ST_WAIT: state_n = cnt == 3'(WAIT_STATES) ? ST_IDLE : ST_WAIT;
      ST_ERR1: state_n = ST_ERR2;
      default: state_n = !acc ? ST_IDLE : err ? ST_ERR1 : WAIT_STATES > 0 ? ST_WAIT : ST_IDLE;
    endcase
    cnt_n = state_n != ST_WAIT ? 3'd0 : state == ST_WAIT ? cnt + 3'd1 : 3'd1;
  end
  // state, wait counter and data-phase control flags
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state    <= ST_IDLE;
      cnt      <= 3'd0;
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      rd_phase <= 1'b0;
      fwd      <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (HREADY) begin
        dp_valid <= ok;
        dp_write <= HWRITE;
        rd_phase <= ok & ~HWRITE;
        fwd      <= ok & ~HWRITE & commit & (dp_word == word);
      end
    end
  end
  // data-phase address/strobes and the write bytes captured for forwarding
  always_ff @(posedge HCLK) begin
    if (HREADY) begin
      dp_be    <= be;
      dp_word  <= word;
      fwd_be   <= dp_be;
      fwd_data <= HWDATA;
    end
  end
endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// tb_ahb_lite_sram_slave: table-driven and sequence checks of the AHB-Lite SRAM slave at 0, 3 and 2 wait states
module tb_ahb_lite_sram_slave;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic hreset, hsel, hwrite;
  logic [31:0] haddr, hwdata;
  logic [1:0] htrans;
  logic [2:0] hsize;
  logic [31:0] rd0, rd3, rd2, rd_m;
  logic rdy0, rdy3, rdy2, rs0, rs3, rs2, rdy_m, resp_m;
  int sel;
  int n_cmp = 0;
  int n_bad = 0;
  assign rd_m   = sel == 0 ? rd0 : sel == 1 ? rd3 : rd2;
  assign rdy_m  = sel == 0 ? rdy0 : sel == 1 ? rdy3 : rdy2;
  assign resp_m = sel == 0 ? rs0 : sel == 1 ? rs3 : rs2;
  ahb_lite_sram_slave #(.MEM_AW(12), .WAIT_STATES(0)) u0 (
    .HCLK(clk), .HRESET(hreset), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans), .HSIZE(hsize),
    .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(rdy0), .HBURST(3'd0), .HPROT(4'd3), .HMASTLOCK(1'b0),
    .HRDATA(rd0), .HREADYOUT(rdy0), .HRESP(rs0));
  ahb_lite_sram_slave #(.MEM_AW(12), .WAIT_STATES(3)) u3 (
    .HCLK(clk), .HRESET(hreset), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans), .HSIZE(hsize),
    .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(rdy3), .HBURST(3'd0), .HPROT(4'd3), .HMASTLOCK(1'b0),
    .HRDATA(rd3), .HREADYOUT(rdy3), .HRESP(rs3));
  ahb_lite_sram_slave #(.MEM_AW(12), .WAIT_STATES(2)) u2 (
    .HCLK(clk), .HRESET(hreset), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans), .HSIZE(hsize),
    .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(rdy2), .HBURST(3'd0), .HPROT(4'd3), .HMASTLOCK(1'b0),
    .HRDATA(rd2), .HREADYOUT(rdy2), .HRESP(rs2));
  typedef struct packed {
    logic [1:0]  sel;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_resp;
    logic [3:0]  exp_waits;
  } vec_t;
  vec_t vecs[22];
  function automatic vec_t mk(input int s, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                              input logic [31:0] wd, input logic [31:0] er, input bit ers, input int ew);
    vec_t v;
    v.sel = 2'(s);
    v.wr = wr;
    v.addr = a;
    v.size = sz;
    v.wdata = wd;
    v.exp_rd = er;
    v.exp_resp = ers;
    v.exp_waits = 4'(ew);
    return v;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic xfer(input vec_t v, output logic [31:0] rd, output logic rs, output int w);
    @(negedge clk);
    hsel = 1'b1; htrans = 2'b10; haddr = v.addr; hsize = v.size; hwrite = v.wr;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = v.wdata;
    @(negedge clk);
    w = 0;
    while (!rdy_m && w < 20) begin
      w++;
      @(negedge clk);
    end
    rd = rd_m;
    rs = resp_m;
    @(posedge clk);
  endtask
  task automatic apply(input int lo, input int hi);
    logic [31:0] rd;
    logic rs;
    int w;
    for (int i = lo; i <= hi; i++) begin
      sel = int'(vecs[i].sel);
      xfer(vecs[i], rd, rs, w);
      chk($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d hresp", i), 32'(rs), 32'(vecs[i].exp_resp));
      chk($sformatf("vec%0d waits", i), 32'(w), 32'(vecs[i].exp_waits));
    end
  endtask
  task automatic idle(input int n);
    @(negedge clk);
    hsel = 1'b0; htrans = 2'b00;
    repeat (n) @(posedge clk);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    hreset = 1'b1; hsel = 1'b0; htrans = 2'b00; haddr = '0; hsize = 3'd0; hwrite = 1'b0; hwdata = '0; sel = 0;
    vecs[0]  = mk(0, 1, 32'h10,   3'd2, 32'hDEADBEEF, 32'h0,        0, 0);
    vecs[1]  = mk(0, 0, 32'h10,   3'd2, 32'h0,        32'hDEADBEEF, 0, 0);
    vecs[2]  = mk(0, 1, 32'h10,   3'd2, 32'h11223344, 32'h0,        0, 0);
    vecs[3]  = mk(0, 0, 32'h10,   3'd2, 32'h0,        32'h11223344, 0, 0);
    vecs[4]  = mk(0, 1, 32'h3FFC, 3'd2, 32'hCAFEF00D, 32'h0,        0, 0);
    vecs[5]  = mk(0, 0, 32'h3FFC, 3'd2, 32'h0,        32'hCAFEF00D, 0, 0);
    vecs[6]  = mk(0, 1, 32'h20,   3'd2, 32'h01020304, 32'h0,        0, 0);
    vecs[7]  = mk(0, 1, 32'h22,   3'd1, 32'hBEEF0000, 32'h0,        0, 0);
    vecs[8]  = mk(0, 1, 32'h21,   3'd0, 32'h0000AB00, 32'h0,        0, 0);
    vecs[9]  = mk(0, 0, 32'h22,   3'd1, 32'h0,        32'hBEEFAB04, 0, 0);
    vecs[10] = mk(0, 0, 32'h23,   3'd0, 32'h0,        32'hBEEFAB04, 0, 0);
    vecs[11] = mk(0, 0, 32'h01,   3'd1, 32'h0,        32'h0,        1, 1);
    vecs[12] = mk(0, 0, 32'h00,   3'd3, 32'h0,        32'h0,        1, 1);
    vecs[13] = mk(0, 1, 32'h12,   3'd2, 32'hFFFFFFFF, 32'h0,        1, 1);
    vecs[14] = mk(0, 1, 32'h11,   3'd1, 32'hFFFFFFFF, 32'h0,        1, 1);
    vecs[15] = mk(0, 0, 32'h10,   3'd2, 32'h0,        32'hAA223344, 0, 0);
    vecs[16] = mk(1, 1, 32'h20,   3'd2, 32'h12345678, 32'h0,        0, 3);
    vecs[17] = mk(1, 0, 32'h20,   3'd2, 32'h0,        32'h12345678, 0, 3);
    vecs[18] = mk(2, 1, 32'h30,   3'd2, 32'h55555555, 32'h0,        0, 2);
    vecs[19] = mk(2, 0, 32'h30,   3'd2, 32'h0,        32'h55555555, 0, 2);
    vecs[20] = mk(2, 0, 32'h30,   3'd2, 32'h0,        32'h55555555, 0, 2);
    vecs[21] = mk(0, 0, 32'h3FFC, 3'd2, 32'h0,        32'hCAFEF00D, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      sel = k;
      #1;
      chk($sformatf("reset%0d hreadyout", k), 32'(rdy_m), 32'd1);
      chk($sformatf("reset%0d hresp", k), 32'(resp_m), 32'd0);
      chk($sformatf("reset%0d hrdata", k), rd_m, 32'h0);
    end
    hreset = 1'b0;
    sel = 0;
    apply(0, 13);
    @(negedge clk);
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h13; hsize = 3'd0; hwrite = 1'b1;
    @(posedge clk); #1;
    hwdata = 32'hAA000000; haddr = 32'h10; hsize = 3'd2; hwrite = 1'b0;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00;
    @(negedge clk);
    chk("fwd hrdata", rd_m, 32'hAA223344);
    chk("fwd hreadyout", 32'(rdy_m), 32'd1);
    chk("fwd hresp", 32'(resp_m), 32'd0);
    apply(14, 15);
    @(negedge clk);
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h4000; hsize = 3'd2; hwrite = 1'b0;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00;
    @(negedge clk);
    chk("oor err1 hreadyout", 32'(rdy_m), 32'd0);
    chk("oor err1 hresp", 32'(resp_m), 32'd1);
    chk("oor err1 hrdata", rd_m, 32'h0);
    @(negedge clk);
    chk("oor err2 hreadyout", 32'(rdy_m), 32'd1);
    chk("oor err2 hresp", 32'(resp_m), 32'd1);
    @(negedge clk);
    chk("oor idle hreadyout", 32'(rdy_m), 32'd1);
    chk("oor idle hresp", 32'(resp_m), 32'd0);
    idle(10);
    apply(16, 17);
    idle(10);
    apply(18, 19);
    @(negedge clk);
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h30; hsize = 3'd2; hwrite = 1'b1;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'h99999999;
    @(negedge clk);
    chk("rst_mid wait hreadyout", 32'(rdy_m), 32'd0);
    hreset = 1'b1;
    @(posedge clk); #1;
    hreset = 1'b0;
    @(negedge clk);
    chk("rst_mid hreadyout", 32'(rdy_m), 32'd1);
    chk("rst_mid hresp", 32'(resp_m), 32'd0);
    chk("rst_mid hrdata", rd_m, 32'h0);
    apply(20, 21);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
